snake_draw_sequencer: RTL and testbench

Frame-update draw controller for the snake game. On each animation tick it snapshots the snake segment list, the vacated tail cell and the apple position, then drives the `vga_adapter` plot port one pixel per clock. It erases the old tail, redraws every body cell and draws the apple, then pulses `done` so the movement logic can advance the segment shift register. It is the only master of the VGA plot port in the game top level.

---
 rtl/snake_draw_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_snake_draw_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_draw_sequencer.sv
// Frame draw controller: snapshots the snake/tail/apple state on tick and rasters
// erase, body and apple rectangles onto the VGA plot port, one pixel per clock.
module snake_draw_sequencer #(
   parameter int XDIM    = 10,
   parameter int YDIM    = 10,
   parameter int MAXLEN  = 4,
   parameter int XSCREEN = 160,
   parameter int YSCREEN = 120
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic                  tick,
   input  logic [2:0]            length,
   input  logic [8*MAXLEN-1:0]   snake_x,
   input  logic [7*MAXLEN-1:0]   snake_y,
   input  logic [7:0]            tail_x,
   input  logic [6:0]            tail_y,
   input  logic                  tail_valid,
   input  logic [7:0]            apple_x,
   input  logic [6:0]            apple_y,
   input  logic                  apple_en,
   input  logic [2:0]            snake_colour,
   input  logic [2:0]            apple_colour,
   output logic [7:0]            VGA_X,
   output logic [6:0]            VGA_Y,
   output logic [2:0]            VGA_COLOR,
   output logic                  plot,
   output logic                  busy,
   output logic                  done
);

   localparam logic [7:0] XLAST = 8'(XDIM - 1);
   localparam logic [6:0] YLAST = 7'(YDIM - 1);
   localparam logic [8:0] XLIM  = 9'(XSCREEN);
   localparam logic [7:0] YLIM  = 8'(YSCREEN);
   localparam logic [2:0] MAXL  = (MAXLEN > 7) ? 3'd7 : 3'(MAXLEN);

   typedef enum logic [2:0] {IDLE, LOAD, ERASE, BODY, APPLE, DONE} state_t;

   state_t state_reg, state_next;
   logic [7:0] xc_reg, xc_next;
   logic [6:0] yc_reg, yc_next;
   logic [2:0] idx_reg, idx_next;

   logic [8*MAXLEN-1:0] snap_x_reg;
   logic [7*MAXLEN-1:0] snap_y_reg;
   logic [7:0] tail_x_reg, apple_x_reg;
   logic [6:0] tail_y_reg, apple_y_reg;
   logic       apple_en_reg;
   logic [2:0] snake_col_reg, apple_col_reg, len_reg;

   // During LOAD the first pixel is formed straight from the inputs being captured.
   logic                is_load;
   logic [8*MAXLEN-1:0] snap_x_sel;
   logic [7*MAXLEN-1:0] snap_y_sel;
   logic [7:0]          tail_x_sel, apple_x_sel;
   logic [6:0]          tail_y_sel, apple_y_sel;
   logic [2:0]          snake_col_sel, apple_col_sel, len_load;

   assign is_load       = (state_reg == LOAD);
   assign snap_x_sel    = is_load ? snake_x      : snap_x_reg;
   assign snap_y_sel    = is_load ? snake_y      : snap_y_reg;
   assign tail_x_sel    = is_load ? tail_x       : tail_x_reg;
   assign tail_y_sel    = is_load ? tail_y       : tail_y_reg;
   assign apple_x_sel   = is_load ? apple_x      : apple_x_reg;
   assign apple_y_sel   = is_load ? apple_y      : apple_y_reg;
   assign snake_col_sel = is_load ? snake_colour : snake_col_reg;
   assign apple_col_sel = is_load ? apple_colour : apple_col_reg;
   assign len_load      = (length == 3'd0) ? 3'd1 : ((length > MAXL) ? MAXL : length);

   logic last_col, last_row;
   assign last_col = (xc_reg == XLAST);
   assign last_row = (yc_reg == YLAST);

   always_comb begin
      state_next = state_reg;
      xc_next    = xc_reg;
      yc_next    = yc_reg;
      idx_next   = idx_reg;
      case (state_reg)
         IDLE: begin
            if (tick) begin
               state_next = LOAD;
               xc_next    = 8'd0;
               yc_next    = 7'd0;
               idx_next   = 3'd0;
            end
         end
         LOAD: begin
            xc_next    = 8'd0;
            yc_next    = 7'd0;
            idx_next   = 3'd0;
            state_next = tail_valid ? ERASE : BODY;
         end
         ERASE, BODY, APPLE: begin
            if (!last_col) begin
               xc_next = xc_reg + 8'd1;
            end else begin
               xc_next = 8'd0;
               if (!last_row) begin
                  yc_next = yc_reg + 7'd1;
               end else begin
                  yc_next = 7'd0;
                  case (state_reg)
                     ERASE: state_next = BODY;
                     BODY: begin
                        if (idx_reg < len_reg - 3'd1) idx_next = idx_reg + 3'd1;
                        else state_next = apple_en_reg ? APPLE : DONE;
                     end
                     default: state_next = DONE;
                  endcase
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pixel for the cycle being entered, registered at the same edge as the state.
   logic [7:0] base_x;
   logic [6:0] base_y;
   logic [2:0] pix_col;
   logic       drawing;
   logic [8:0] sum_x;
   logic [7:0] sum_y;

   always_comb begin
      base_x  = 8'd0;
      base_y  = 7'd0;
      pix_col = 3'd0;
      drawing = 1'b1;
      case (state_next)
         ERASE: begin
            base_x = tail_x_sel;
            base_y = tail_y_sel;
         end
         BODY: begin
            base_x  = snap_x_sel[32'(idx_next) * 8 +: 8];
            base_y  = snap_y_sel[32'(idx_next) * 7 +: 7];
            pix_col = snake_col_sel;
         end
         APPLE: begin
            base_x  = apple_x_sel;
            base_y  = apple_y_sel;
            pix_col = apple_col_sel;
         end
         default: drawing = 1'b0;
      endcase
      sum_x = {1'b0, base_x} + {1'b0, xc_next};
      sum_y = {1'b0, base_y} + {1'b0, yc_next};
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_reg     <= IDLE;
         xc_reg        <= 8'd0;
         yc_reg        <= 7'd0;
         idx_reg       <= 3'd0;
         snap_x_reg    <= '0;
         snap_y_reg    <= '0;
         tail_x_reg    <= 8'd0;
         tail_y_reg    <= 7'd0;
         apple_x_reg   <= 8'd0;
         apple_y_reg   <= 7'd0;
         apple_en_reg  <= 1'b0;
         snake_col_reg <= 3'd0;
         apple_col_reg <= 3'd0;
         len_reg       <= 3'd0;
         VGA_X         <= 8'd0;
         VGA_Y         <= 7'd0;
         VGA_COLOR     <= 3'd0;
         plot          <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state_reg <= state_next;
         xc_reg    <= xc_next;
         yc_reg    <= yc_next;
         idx_reg   <= idx_next;
         if (is_load) begin
            snap_x_reg    <= snake_x;
            snap_y_reg    <= snake_y;
            tail_x_reg    <= tail_x;
            tail_y_reg    <= tail_y;
            apple_x_reg   <= apple_x;
            apple_y_reg   <= apple_y;
            apple_en_reg  <= apple_en;
            snake_col_reg <= snake_colour;
            apple_col_reg <= apple_colour;
            len_reg       <= len_load;
         end
         VGA_X     <= drawing ? sum_x[7:0] : 8'd0;
         VGA_Y     <= drawing ? sum_y[6:0] : 7'd0;
         VGA_COLOR <= drawing ? pix_col : 3'd0;
         plot      <= drawing && (sum_x < XLIM) && (sum_y < YLIM);
         busy      <= (state_next != IDLE);
         done      <= (state_next == DONE);
      end
   end

endmodule

// File: tb/tb_snake_draw_sequencer.sv
// Scoreboard bench for snake_draw_sequencer: a reference raster model queues every
// expected pixel cycle per frame, and each DUT cycle pops and compares one entry.
module tb_snake_draw_sequencer;

   localparam int XDIM = 10, YDIM = 10, MAXLEN = 4;

   logic                Clock = 1'b0;
   logic                Resetn;
   logic                tick;
   logic [2:0]          length;
   logic [8*MAXLEN-1:0] snake_x;
   logic [7*MAXLEN-1:0] snake_y;
   logic [7:0]          tail_x, apple_x;
   logic [6:0]          tail_y, apple_y;
   logic                tail_valid, apple_en;
   logic [2:0]          snake_colour, apple_colour;
   logic [7:0]          VGA_X;
   logic [6:0]          VGA_Y;
   logic [2:0]          VGA_COLOR;
   logic                plot, busy, done;

   snake_draw_sequencer dut (
      .Clock(Clock), .Resetn(Resetn), .tick(tick), .length(length),
      .snake_x(snake_x), .snake_y(snake_y), .tail_x(tail_x), .tail_y(tail_y),
      .tail_valid(tail_valid), .apple_x(apple_x), .apple_y(apple_y), .apple_en(apple_en),
      .snake_colour(snake_colour), .apple_colour(apple_colour),
      .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR),
      .plot(plot), .busy(busy), .done(done)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   logic [20:0] exp_q[$];

   always @(posedge Clock) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // {busy, done, plot, x, y, colour}
   function automatic logic [20:0] pk(input logic p, input logic [7:0] x,
                                      input logic [6:0] y, input logic [2:0] c);
      return {1'b1, 1'b0, p, x, y, c};
   endfunction

   function automatic logic [20:0] dut_word();
      return {busy, done, plot, VGA_X, VGA_Y, VGA_COLOR};
   endfunction

   task automatic push_rect(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] col);
      for (int yy = 0; yy < YDIM; yy++) begin
         for (int xx = 0; xx < XDIM; xx++) begin
            logic [8:0] sx;
            logic [7:0] sy;
            sx = {1'b0, bx} + 9'(xx);
            sy = {1'b0, by} + 8'(yy);
            exp_q.push_back(pk((sx < 9'd160) && (sy < 8'd120), sx[7:0], sy[6:0], col));
         end
      end
   endtask

   task automatic build_expected();
      int len;
      len = (length == 0) ? 1 : ((length > MAXLEN) ? MAXLEN : int'(length));
      exp_q.delete();
      if (tail_valid) push_rect(tail_x, tail_y, 3'b000);
      for (int i = 0; i < len; i++) push_rect(snake_x[8*i +: 8], snake_y[7*i +: 7], snake_colour);
      if (apple_en) push_rect(apple_x, apple_y, apple_colour);
   endtask

   // Entered and left on a negedge. abort_at/mutate_at are frame cycle numbers (0 = tick edge).
   task automatic run_frame(input string name, input bit hold, input int abort_at, input int mutate_at,
                            output int plots, output int start_cyc,
                            output logic [20:0] px0, output logic [20:0] px100, output logic [20:0] plast);
      int p, d0;
      logic [20:0] got;
      plots = 0; px0 = '0; px100 = '0; plast = '0;
      build_expected();
      p  = exp_q.size();
      d0 = done_cnt;
      tick = 1'b1;
      @(posedge Clock);
      start_cyc = cyc;
      @(negedge Clock);
      if (!hold) tick = 1'b0;
      check({name, "_load"}, {29'd0, busy, done, plot}, 32'b100);
      for (int k = 0; k < p; k++) begin
         @(negedge Clock);
         got = dut_word();
         check({name, "_px"}, 32'(got), 32'(exp_q.pop_front()));
         if (plot) plots++;
         if (k == 0) px0 = got;
         if (k == 100) px100 = got;
         if (k == p - 1) plast = got;
         if (k + 2 == mutate_at) snake_x[7:0] = snake_x[7:0] + 8'd20;
         if (k + 2 == abort_at) begin
            #2 Resetn = 1'b0;
            #1 check({name, "_rst_async"}, 32'(dut_word()), 32'd0);
            exp_q.delete();
            repeat (3) @(negedge Clock);
            check({name, "_rst_no_done"}, 32'(done_cnt - d0), 32'd0);
            check({name, "_rst_idle"}, {30'd0, busy, plot}, 32'd0);
            Resetn = 1'b1;
            @(negedge Clock);
            $display("frame %s: aborted by reset at cycle %0d", name, abort_at);
            return;
         end
      end
      @(negedge Clock);
      check({name, "_done"}, {29'd0, busy, done, plot}, 32'b110);
      @(negedge Clock);
      check({name, "_idle"}, {29'd0, busy, done, plot}, 32'b000);
      check({name, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
      $display("frame %s: %0d raster cycles, %0d plots, start cycle %0d", name, p, plots, start_cyc);
   endtask

   task automatic set_frame_a();
      length       = 3'd4;
      snake_x      = {8'd9, 8'd19, 8'd29, 8'd39};
      snake_y      = {7'd59, 7'd59, 7'd59, 7'd59};
      tail_x       = 8'd0;   tail_y  = 7'd59; tail_valid = 1'b1;
      apple_x      = 8'd80;  apple_y = 7'd60; apple_en   = 1'b1;
      snake_colour = 3'b010; apple_colour = 3'b100;
   endtask

   task automatic set_single(input logic [7:0] hx, input logic [6:0] hy, input logic [2:0] len);
      length     = len;
      snake_x    = {24'd0, hx};
      snake_y    = {21'd0, hy};
      tail_valid = 1'b0;
      apple_en   = 1'b0;
   endtask

   int plots, s1, s2, d_before;
   logic [20:0] p0, p100, pl;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      Resetn = 1'b0;
      tick   = 1'b0;
      set_frame_a();
      repeat (3) @(negedge Clock);
      check("reset_outputs", 32'({busy, done, plot, VGA_X, VGA_Y, VGA_COLOR}), 32'd0);
      Resetn = 1'b1;
      @(negedge Clock);

      // Reset in the middle of BODY, then a clean frame with a mid-frame head change
      run_frame("reset_mid", 1'b0, 250, -1, plots, s1, p0, p100, pl);
      set_frame_a();
      run_frame("full", 1'b0, -1, 120, plots, s1, p0, p100, pl);
      check("full_plots", 32'(plots), 32'd600);
      check("full_first", 32'(p0), 32'(pk(1'b1, 8'd0, 7'd59, 3'b000)));
      check("full_px100", 32'(p100), 32'(pk(1'b1, 8'd39, 7'd59, 3'b010)));
      check("full_last", 32'(pl), 32'(pk(1'b1, 8'd89, 7'd69, 3'b100)));

      // Next frame must pick up the changed head position
      run_frame("after_mutate", 1'b0, -1, -1, plots, s1, p0, p100, pl);
      check("mutate_px100", 32'(p100), 32'(pk(1'b1, 8'd59, 7'd59, 3'b010)));

      set_single(8'd50, 7'd50, 3'd0);
      run_frame("len0", 1'b0, -1, -1, plots, s1, p0, p100, pl);
      check("len0_plots", 32'(plots), 32'd100);
      check("len0_last", 32'(pl), 32'(pk(1'b1, 8'd59, 7'd59, 3'b010)));

      set_single(8'd155, 7'd115, 3'd1);
      run_frame("clip", 1'b0, -1, -1, plots, s1, p0, p100, pl);
      check("clip_plots", 32'(plots), 32'd25);

      set_single(8'd20, 7'd30, 3'd7);
      run_frame("len7", 1'b0, -1, -1, plots, s1, p0, p100, pl);
      check("len7_plots", 32'(plots), 32'd400);

      set_single(8'd70, 7'd40, 3'd1);
      d_before = done_cnt;
      run_frame("held1", 1'b1, -1, -1, plots, s1, p0, p100, pl);
      run_frame("held2", 1'b1, -1, -1, plots, s2, p0, p100, pl);
      tick = 1'b0;
      check("held_period", 32'(s2 - s1), 32'd103);
      check("held_done_total", 32'(done_cnt - d_before), 32'd2);
      repeat (3) @(negedge Clock);
      check("held_stop", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
